// File: rtl/seq_detector_param.sv
// Parametrised Mealy serial-pattern detector with runtime-programmable
// pattern and overlap mode, registered match pulse and saturating counter.
module seq_detector_param #(
    parameter int           N           = 5,
    parameter logic [N-1:0] DEF_PATTERN = N'(5'b11011),
    parameter bit           DEF_OVERLAP = 1'b1,
    parameter int           CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in,
    input  logic             pat_load,
    input  logic [N-1:0]     pat_in,
    input  logic             ovl_in,
    output logic             det_comb,
    output logic             det,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy_fill
);

    localparam int FW = $clog2(N);
    localparam logic [FW-1:0] FULL = FW'(N - 1);

    logic [N-2:0]  hist;
    logic [FW-1:0] fill;
    logic [N-1:0]  pattern;
    logic          ovl;
    logic [N-1:0]  window;

    // Candidate window: stored history plus the bit arriving this cycle.
    assign window    = {hist, in};
    assign det_comb  = en & ~pat_load & (fill == FULL) & (window == pattern);
    assign busy_fill = (fill < FULL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist      <= '0;
            fill      <= '0;
            pattern   <= DEF_PATTERN;
            ovl       <= DEF_OVERLAP;
            det       <= 1'b0;
            match_cnt <= '0;
        end else begin
            det <= det_comb;
            if (pat_load) begin
                pattern <= pat_in;
                ovl     <= ovl_in;
                fill    <= '0;
                hist    <= '0;
            end else if (en) begin
                hist <= window[N-2:0];
                if (det_comb && !ovl)
                    fill <= '0;
                else if (fill != FULL)
                    fill <= fill + 1'b1;
                if (det_comb && (match_cnt != '1))
                    match_cnt <= match_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed testbench for seq_detector_param (N=5, CNT_W=8).
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       in;
    logic       pat_load;
    logic [4:0] pat_in;
    logic       ovl_in;
    logic       det_comb;
    logic       det;
    logic [7:0] match_cnt;
    logic       busy_fill;

    int total = 0;
    int bad = 0;
    int exp_cnt = 0;

    seq_detector_param #(
        .N(5),
        .DEF_PATTERN(5'b11011),
        .DEF_OVERLAP(1'b1),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .in(in),
        .pat_load(pat_load),
        .pat_in(pat_in),
        .ovl_in(ovl_in),
        .det_comb(det_comb),
        .det(det),
        .match_cnt(match_cnt),
        .busy_fill(busy_fill)
    );

    always #5 clk = ~clk;

    // Drive one accepted bit; called at posedge+1.
    task automatic send(input logic b, output logic dc, output logic dr);
        en = 1'b1;
        in = b;
        #2;
        dc = det_comb;
        @(posedge clk);
        #1;
        dr = det;
        en = 1'b0;
    endtask

    task automatic load(input logic [4:0] p, input logic o);
        pat_load = 1'b1;
        pat_in = p;
        ovl_in = o;
        en = 1'b0;
        @(posedge clk);
        #1;
        pat_load = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        en = 1'b0;
        in = 1'b0;
        pat_load = 1'b0;
        pat_in = '0;
        ovl_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (det !== 1'b0 || det_comb !== 1'b0) begin
            bad++;
            $display("FAIL reset_det got=%b/%b want=0/0", det, det_comb);
        end
        total++;
        if (match_cnt !== 8'd0 || busy_fill !== 1'b1) begin
            bad++;
            $display("FAIL reset_cnt got=%0d busy=%b want=0 busy=1",
                     match_cnt, busy_fill);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_overlap;
        logic [7:0] s;
        logic [7:0] e;
        logic dc, dr;
        s = 8'b11011011;
        e = 8'b00001001;
        for (int i = 0; i < 8; i++) begin
            send(s[7-i], dc, dr);
            total++;
            if (dc !== e[7-i] || dr !== e[7-i]) begin
                bad++;
                $display("FAIL ovl_det bit%0d got=%b/%b want=%b",
                         i + 1, dc, dr, e[7-i]);
            end
            if (i == 2 || i == 3) begin
                total++;
                if (busy_fill !== (i == 2)) begin
                    bad++;
                    $display("FAIL ovl_busy bit%0d got=%b want=%b",
                             i + 1, busy_fill, (i == 2));
                end
            end
        end
        exp_cnt = 2;
        total++;
        if (match_cnt !== 8'(exp_cnt)) begin
            bad++;
            $display("FAIL ovl_cnt got=%0d want=%0d", match_cnt, exp_cnt);
        end
    endtask

    task automatic test_nonoverlap;
        logic [7:0] s;
        logic [7:0] e;
        logic [9:0] s2;
        logic [9:0] e2;
        logic dc, dr;
        s = 8'b11011011;
        e = 8'b00001000;
        s2 = 10'b1101111011;
        e2 = 10'b0000100001;
        load(5'b11011, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send(s[7-i], dc, dr);
            total++;
            if (dc !== e[7-i] || dr !== e[7-i]) begin
                bad++;
                $display("FAIL novl_det bit%0d got=%b/%b want=%b",
                         i + 1, dc, dr, e[7-i]);
            end
        end
        for (int i = 0; i < 10; i++) begin
            send(s2[9-i], dc, dr);
            total++;
            if (dc !== e2[9-i] || dr !== e2[9-i]) begin
                bad++;
                $display("FAIL novl2_det bit%0d got=%b/%b want=%b",
                         i + 1, dc, dr, e2[9-i]);
            end
        end
        exp_cnt = 5;
        total++;
        if (match_cnt !== 8'(exp_cnt)) begin
            bad++;
            $display("FAIL novl_cnt got=%0d want=%0d", match_cnt, exp_cnt);
        end
    endtask

    task automatic test_en_gap;
        logic [3:0] s;
        logic dc, dr;
        s = 4'b1101;
        load(5'b11011, 1'b1);
        for (int i = 0; i < 4; i++) begin
            send(s[3-i], dc, dr);
        end
        en = 1'b0;
        in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            total++;
            if (det_comb !== 1'b0) begin
                bad++;
                $display("FAIL gap_comb cyc%0d got=%b want=0", i, det_comb);
            end
            @(posedge clk);
            #1;
            total++;
            if (det !== 1'b0 || match_cnt !== 8'(exp_cnt)) begin
                bad++;
                $display("FAIL gap_hold cyc%0d det=%b cnt=%0d want=0 %0d",
                         i, det, match_cnt, exp_cnt);
            end
        end
        send(1'b1, dc, dr);
        exp_cnt++;
        total++;
        if (dc !== 1'b1 || dr !== 1'b1 || match_cnt !== 8'(exp_cnt)) begin
            bad++;
            $display("FAIL gap_match got=%b/%b cnt=%0d want=1/1 cnt=%0d",
                     dc, dr, match_cnt, exp_cnt);
        end
    endtask

    task automatic test_midreset;
        logic [3:0] s;
        logic [5:0] s2;
        logic [5:0] e2;
        logic dc, dr;
        s = 4'b1101;
        s2 = 6'b111011;
        e2 = 6'b000001;
        for (int i = 0; i < 4; i++) begin
            send(s[3-i], dc, dr);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (det !== 1'b0 || det_comb !== 1'b0 || match_cnt !== 8'd0 ||
            busy_fill !== 1'b1) begin
            bad++;
            $display("FAIL midrst got det=%b dc=%b cnt=%0d busy=%b want 0 0 0 1",
                     det, det_comb, match_cnt, busy_fill);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            send(s2[5-i], dc, dr);
            total++;
            if (dc !== e2[5-i] || dr !== e2[5-i]) begin
                bad++;
                $display("FAIL midrst_det bit%0d got=%b/%b want=%b",
                         i + 1, dc, dr, e2[5-i]);
            end
        end
        exp_cnt = 1;
        total++;
        if (match_cnt !== 8'(exp_cnt)) begin
            bad++;
            $display("FAIL midrst_cnt got=%0d want=%0d", match_cnt, exp_cnt);
        end
    endtask

    task automatic test_patload_abort;
        logic [3:0] s;
        logic [4:0] s2;
        logic [4:0] e2;
        logic dc, dr;
        s = 4'b1101;
        s2 = 5'b10101;
        e2 = 5'b00001;
        for (int i = 0; i < 4; i++) begin
            send(s[3-i], dc, dr);
        end
        en = 1'b1;
        in = 1'b1;
        pat_load = 1'b1;
        pat_in = 5'b10101;
        ovl_in = 1'b1;
        #2;
        total++;
        if (det_comb !== 1'b0) begin
            bad++;
            $display("FAIL abort_comb got=%b want=0", det_comb);
        end
        @(posedge clk);
        #1;
        pat_load = 1'b0;
        en = 1'b0;
        total++;
        if (det !== 1'b0 || busy_fill !== 1'b1 ||
            match_cnt !== 8'(exp_cnt)) begin
            bad++;
            $display("FAIL abort_state det=%b busy=%b cnt=%0d want 0 1 %0d",
                     det, busy_fill, match_cnt, exp_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            send(s2[4-i], dc, dr);
            total++;
            if (dc !== e2[4-i] || dr !== e2[4-i]) begin
                bad++;
                $display("FAIL newpat_det bit%0d got=%b/%b want=%b",
                         i + 1, dc, dr, e2[4-i]);
            end
        end
        exp_cnt++;
        total++;
        if (match_cnt !== 8'(exp_cnt)) begin
            bad++;
            $display("FAIL newpat_cnt got=%0d want=%0d", match_cnt, exp_cnt);
        end
    endtask

    task automatic test_back_to_back;
        logic dc, dr;
        load(5'b11111, 1'b1);
        for (int i = 0; i < 10; i++) begin
            send(1'b1, dc, dr);
            total++;
            if (dc !== (i >= 4) || dr !== (i >= 4)) begin
                bad++;
                $display("FAIL ones_det bit%0d got=%b/%b want=%b",
                         i + 1, dc, dr, (i >= 4));
            end
        end
        exp_cnt += 6;
        total++;
        if (match_cnt !== 8'(exp_cnt)) begin
            bad++;
            $display("FAIL ones_cnt got=%0d want=%0d", match_cnt, exp_cnt);
        end
    endtask

    task automatic test_saturate;
        logic dc, dr;
        for (int i = 0; i < 260; i++) begin
            send(1'b1, dc, dr);
        end
        total++;
        if (match_cnt !== 8'd255 || dc !== 1'b1 || dr !== 1'b1) begin
            bad++;
            $display("FAIL sat_cnt got=%0d det=%b/%b want=255 1/1",
                     match_cnt, dc, dr);
        end
    endtask

    initial begin
        test_reset;
        test_overlap;
        test_nonoverlap;
        test_en_gap;
        test_midreset;
        test_patload_abort;
        test_back_to_back;
        test_saturate;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised Mealy serial-pattern detector for the FSM library; successor to the fixed 5-bit "11011" overlapping detector.
- Pattern width is set at elaboration. Pattern value and overlap mode are programmable at runtime.
- Provides a combinational Mealy match, a registered match pulse and a saturating match counter.
- Sits on a 1-bit serial input stream, qualified by an enable.

Parameters:
N, 5, pattern length in bits; legal range 2..32.
DEF_PATTERN, 5'b11011, pattern loaded at reset; width N; MSB is the oldest bit.
DEF_OVERLAP, 1, overlap mode at reset; 1 = overlapping, 0 = non-overlapping.
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset.
en  input  1  serial-bit qualifier; `in` is consumed only when en=1.
in  input  1  serial data bit.
pat_load  input  1  when 1 at a clock edge: load pat_in and ovl_in, and flush history.
pat_in  input  N  new pattern; MSB is the first-received bit.
ovl_in  input  1  new overlap mode.
det_comb  output  1  Mealy match: combinational from `in` and current state.
det  output  1  registered match: det_comb delayed by one clock.
match_cnt  output  CNT_W  count of matches since reset; saturates at all-ones.
busy_fill  output  1  1 while fewer than N-1 valid history bits are held.

Behaviour:
- State registers:
  - hist[N-2:0]: last N-1 accepted bits; bit 0 is the newest.
  - fill: 0..N-1, count of valid history bits.
  - pattern[N-1:0].
  - ovl.
  - det.
  - match_cnt.
- Reset (rst=0, async):
  - hist=0, fill=0, pattern=DEF_PATTERN, ovl=DEF_OVERLAP.
  - det=0, match_cnt=0; therefore busy_fill=1.
  - det_comb=0, because fill<N-1 gates it.
- det_comb = en & ~pat_load & (fill==N-1) & ({hist,in}==pattern).
  - Asserts in the same cycle as the last pattern bit.
- On each edge with en=1 and pat_load=0:
  - hist <= {hist[N-3:0],in}.
  - fill <= min(fill+1, N-1).
- On a match edge (det_comb=1):
  - ovl=1: history shifts normally, so a suffix of a match can start the next one.
  - ovl=0: fill <= 0. A new match needs N fresh bits after the matching bit.
  - match_cnt <= match_cnt+1, unless it is already all-ones (then it holds).
- det <= det_comb every edge. One-cycle pulse per match; back-to-back pulses are legal in overlap mode.
- en=0: hist, fill and match_cnt hold; det_comb=0, so det drops to 0 on the next edge.
- pat_load=1:
  - Takes priority over en/in; the bit at that edge is not consumed.
  - pattern <= pat_in, ovl <= ovl_in, fill <= 0, hist <= 0.
  - match_cnt is not cleared.
  - det_comb is forced to 0 that cycle.
- Degenerate patterns (all-ones, all-zeros) in overlap mode match on every bit once fill==N-1.
- Reset asserted mid-stream: everything is cleared immediately. The first match after release needs N accepted bits.
- busy_fill = (fill < N-1).
- No other latency: detection is 0 cycles (det_comb) or 1 cycle (det) after the final bit's edge.

Test Plan:
- Reset default (N=5, 11011, ovl=1), en=1, in stream 1,1,0,1,1,0,1,1 → det_comb high on bits 5 and 8 → det high the cycle after each → match_cnt=2.
- pat_load with pat_in=11011, ovl_in=0, same stream 1,1,0,1,1,0,1,1 → single match at bit 5. Then stream 1,1,0,1,1,1,1,0,1,1 → matches at bits 5 and 10 only → cnt +2.
- Stream 1,1,0,1 with en dropped for 3 cycles between bits 4 and 5, then in=1 → match on the 5th accepted bit. det stays 0 during the en=0 cycles.
- Assert rst low after 1,1,0,1 and release → all outputs 0, busy_fill=1. Then 1,1,1,0,1,1 → exactly one match (at bit 6).
- pat_in=11111, ovl=1 (any N-bit pattern); 10 consecutive 1s → det high on bits 5..10 (6 pulses). With CNT_W=2, match_cnt saturates at 3.
- pat_load pulsed on the cycle that would complete 11011 → no match, fill=0. match_cnt holds its value and pattern reflects pat_in.
